kem_seq_ctrl: RTL and testbench

Parametrised top-level sequencer for the ML-KEM core: it accepts a one-hot KEYGEN/ENCAP/DECAP request and steps through a per-mode list of sub-engine invocations, for example TRNG, SHA3 and NTT. For each step it issues a one-cycle start pulse, waits for that engine's done, and enforces a per-step timeout. It tracks whether a valid key pair exists, so DECAP is legal only after KEYGEN, and reports completion with an error code. It sits between the ML_KEM host interface and the arithmetic and hash engines.

---
 rtl/kem_seq_ctrl_pkg.sv | 39 +++
 rtl/kem_step_timer.sv | 38 +++
 rtl/kem_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_kem_seq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kem_seq_ctrl_pkg.sv
// Shared types for the ML-KEM top-level sequencer.
package kem_seq_ctrl_pkg;

    // One-hot operation request from the host.
    typedef enum logic [2:0] {
        MODE_KEYGEN = 3'b001,
        MODE_ENCAP  = 3'b010,
        MODE_DECAP  = 3'b100
    } kem_mode_t;

    // Completion status reported alongside done_o.
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BADMODE = 2'd1,
        ERR_NOKEY   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } kem_err_t;

    // Raw state codes, kept for tools that only see plain vectors.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_DONE  = ST_DONE,
        S_ERROR = ST_ERROR
    } kem_seq_state_t;

    // True when exactly one request bit is set.
    function automatic logic mode_is_onehot(input logic [2:0] m);
        return (m == 3'b001) || (m == 3'b010) || (m == 3'b100);
    endfunction

endpackage

// File: rtl/kem_step_timer.sv
// Per-step watchdog: saturating cycle counter flagging the last allowed WAIT cycle.
module kem_step_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // Clear wins; otherwise count while enabled and stick at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/kem_seq_ctrl.sv
// ML-KEM top-level sequencer: walks a per-mode list of engine invocations.
module kem_seq_ctrl
    import kem_seq_ctrl_pkg::*;
#(
    parameter int unsigned N_ENG     = 4,
    parameter int unsigned IDX_W     = $clog2(N_ENG),
    parameter int unsigned MAX_STEPS = 8,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned KG_LEN    = 3,
    parameter int unsigned EN_LEN    = 4,
    parameter int unsigned DE_LEN    = 4,
    parameter logic [MAX_STEPS*IDX_W-1:0] KG_SEQ = (MAX_STEPS*IDX_W)'(32'h0000_0024),
    parameter logic [MAX_STEPS*IDX_W-1:0] EN_SEQ = (MAX_STEPS*IDX_W)'(32'h0000_00E4),
    parameter logic [MAX_STEPS*IDX_W-1:0] DE_SEQ = (MAX_STEPS*IDX_W)'(32'h0000_0079)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic                                   run_i,
    input  kem_mode_t                              mode_i,
    input  logic                                   abort_i,
    output logic [N_ENG-1:0]                       start_o,
    input  logic [N_ENG-1:0]                       done_i,
    output logic                                   ready_o,
    output logic                                   busy_o,
    output logic [((MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1)-1:0] step_o,
    output logic                                   done_o,
    output logic                                   err_o,
    output kem_err_t                               err_code_o,
    output logic                                   key_valid_o
);

    localparam int unsigned SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    // Reject impossible step counts at elaboration.
    if (KG_LEN < 1 || KG_LEN > MAX_STEPS) begin : g_bad_kg_len
        $error("KG_LEN must be in 1..MAX_STEPS");
    end
    if (EN_LEN < 1 || EN_LEN > MAX_STEPS) begin : g_bad_en_len
        $error("EN_LEN must be in 1..MAX_STEPS");
    end
    if (DE_LEN < 1 || DE_LEN > MAX_STEPS) begin : g_bad_de_len
        $error("DE_LEN must be in 1..MAX_STEPS");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    kem_seq_state_t state_q, state_d;
    kem_mode_t      mode_q, mode_d;
    kem_err_t       err_q, err_d;
    logic [SW-1:0]  step_q, step_d;
    logic           key_valid_q, key_valid_d;

    logic [MAX_STEPS*IDX_W-1:0] seq_c;
    logic [SW-1:0]              last_c;
    logic [IDX_W-1:0]           eng_c;
    logic                       tmo_c;

    // Engine for the current step, selected from the latched mode's list.
    always_comb begin
        seq_c  = KG_SEQ;
        last_c = SW'(KG_LEN - 1);
        case (mode_q)
            MODE_ENCAP: begin
                seq_c  = EN_SEQ;
                last_c = SW'(EN_LEN - 1);
            end
            MODE_DECAP: begin
                seq_c  = DE_SEQ;
                last_c = SW'(DE_LEN - 1);
            end
            default: ;
        endcase
        eng_c = seq_c[step_q*IDX_W +: IDX_W];
    end

    kem_step_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (state_q == S_ISSUE),
        .en_i      (state_q == S_WAIT),
        .expired_o (tmo_c)
    );

    // Next-state logic; abort overrides every other input.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        err_d       = err_q;
        step_d      = step_q;
        key_valid_d = key_valid_q;
        if (abort_i) begin
            state_d     = S_IDLE;
            step_d      = '0;
            key_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        if (!mode_is_onehot(mode_i)) begin
                            state_d = S_ERROR;
                            err_d   = ERR_BADMODE;
                        end else if ((mode_i == MODE_DECAP) && !key_valid_q) begin
                            state_d = S_ERROR;
                            err_d   = ERR_NOKEY;
                        end else begin
                            state_d = S_ISSUE;
                            mode_d  = mode_i;
                            step_d  = '0;
                            err_d   = ERR_NONE;
                        end
                    end
                end
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    // A done in the last allowed cycle beats the timeout.
                    if (done_i[eng_c]) begin
                        if (step_q == last_c) begin
                            state_d = S_DONE;
                            if (mode_q == MODE_KEYGEN) begin
                                key_valid_d = 1'b1;
                            end
                        end else begin
                            state_d = S_ISSUE;
                            step_d  = step_q + SW'(1);
                        end
                    end else if (tmo_c) begin
                        state_d = S_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    err_d   = ERR_NONE;
                end
                S_ERROR: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, context and status registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_KEYGEN;
            err_q       <= ERR_NONE;
            step_q      <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
            step_q      <= step_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Start pulse decoded purely from the state and step registers.
    always_comb begin
        start_o = '0;
        if (state_q == S_ISSUE) begin
            start_o[eng_c] = 1'b1;
        end
    end

    assign ready_o     = (state_q == S_IDLE);
    assign busy_o      = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done_o      = (state_q == S_DONE) || (state_q == S_ERROR);
    assign err_o       = (state_q == S_ERROR);
    assign step_o      = step_q;
    assign err_code_o  = err_q;
    assign key_valid_o = key_valid_q;

endmodule

// File: tb/tb_kem_seq_ctrl.sv
// Randomized self-checking bench for kem_seq_ctrl against a request-level model.
module tb_kem_seq_ctrl;
    import kem_seq_ctrl_pkg::*;

    localparam int unsigned TO = 16;

    logic      clk_i = 1'b0;
    logic      rst_n_i;
    logic      run_i;
    kem_mode_t mode_i;
    logic      abort_i;
    logic [3:0] start_o;
    logic [3:0] done_i;
    logic      ready_o, busy_o, done_o, err_o, key_valid_o;
    logic [2:0] step_o;
    kem_err_t  err_code_o;
    logic [8:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: engine lists per mode (keygen, encap, decap) and key state.
    int seq_tab [3][4] = '{'{0, 1, 2, 0}, '{0, 1, 2, 3}, '{1, 2, 3, 1}};
    int len_tab [3]    = '{3, 4, 4};
    bit kv_m = 1'b0;

    always #5 clk_i = ~clk_i;

    assign obs = {ready_o, busy_o, done_o, err_o, start_o, key_valid_o};

    kem_seq_ctrl #(
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .run_i       (run_i),
        .mode_i      (mode_i),
        .abort_i     (abort_i),
        .start_o     (start_o),
        .done_i      (done_i),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .step_o      (step_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o),
        .key_valid_o (key_valid_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One full request. k_fixed=0 draws random latencies; hang_k=0 means the
    // hang_step engine never answers; abort_step aborts in that step's first WAIT.
    task automatic drive_request(input logic [2:0] m, input int k_fixed, input int hang_step,
                                 input int hang_k, input int abort_step, input bit noise);
        int mi, len, k;
        bit bad, nokey;
        logic [3:0] sel;
        logic [8:0] exp;
        n_checks++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_ready: got %b want 1", ready_o);
        end
        bad   = !(m == 3'b001 || m == 3'b010 || m == 3'b100);
        nokey = !bad && (m == 3'b100) && !kv_m;
        run_i  = 1'b1;
        mode_i = kem_mode_t'(m);
        tick();
        run_i  = 1'b0;
        mode_i = kem_mode_t'(3'($urandom));
        if (bad || nokey) begin
            exp = {1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, kv_m};
            n_checks++;
            if (obs !== exp || err_code_o !== (bad ? ERR_BADMODE : ERR_NOKEY)) begin
                n_fail++;
                $display("FAIL reject m=%b: got %b/%0d want %b/%0d", m, obs, err_code_o, exp,
                         bad ? 1 : 2);
            end
            tick();
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, kv_m};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reject_idle m=%b: got %b want %b", m, obs, exp);
            end
            return;
        end
        mi  = (m == 3'b001) ? 0 : (m == 3'b010) ? 1 : 2;
        len = len_tab[mi];
        for (int s = 0; s < len; s++) begin
            sel = 4'(1 << seq_tab[mi][s]);
            exp = {1'b0, 1'b1, 1'b0, 1'b0, sel, kv_m};
            n_checks++;
            if (obs !== exp || step_o !== 3'(s)) begin
                n_fail++;
                $display("FAIL issue m=%b s=%0d: got %b step %0d want %b step %0d",
                         m, s, obs, step_o, exp, s);
            end
            done_i = noise ? 4'($urandom) : 4'b0000;
            run_i  = noise ? 1'($urandom) : 1'b0;
            if (s == hang_step)  k = hang_k;
            else if (k_fixed > 0) k = k_fixed;
            else                 k = $urandom_range(1, 3);
            if (k == 0) begin
                for (int j = 1; j <= int'(TO); j++) begin
                    tick();
                    exp = {1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, kv_m};
                    n_checks++;
                    if (obs !== exp) begin
                        n_fail++;
                        $display("FAIL hang_wait j=%0d: got %b want %b", j, obs, exp);
                    end
                    done_i = noise ? (4'($urandom) & ~sel) : 4'b0000;
                end
                tick();
                done_i = 4'b0000;
                run_i  = 1'b0;
                exp = {1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, kv_m};
                n_checks++;
                if (obs !== exp || err_code_o !== ERR_TIMEOUT) begin
                    n_fail++;
                    $display("FAIL timeout: got %b/%0d want %b/3", obs, err_code_o, exp);
                end
                tick();
                exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, kv_m};
                n_checks++;
                if (obs !== exp || err_code_o !== ERR_TIMEOUT) begin
                    n_fail++;
                    $display("FAIL timeout_idle: got %b/%0d want %b/3", obs, err_code_o, exp);
                end
                return;
            end
            for (int j = 1; j <= k; j++) begin
                tick();
                exp = {1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, kv_m};
                n_checks++;
                if (obs !== exp || step_o !== 3'(s)) begin
                    n_fail++;
                    $display("FAIL wait s=%0d j=%0d: got %b step %0d want %b", s, j, obs, step_o, exp);
                end
                if (s == abort_step) begin
                    abort_i = 1'b1;
                    done_i  = sel;
                    run_i   = 1'b1;
                    tick();
                    abort_i = 1'b0;
                    done_i  = 4'b0000;
                    run_i   = 1'b0;
                    kv_m    = 1'b0;
                    exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
                    n_checks++;
                    if (obs !== exp || step_o !== 3'd0) begin
                        n_fail++;
                        $display("FAIL abort: got %b step %0d want %b step 0", obs, step_o, exp);
                    end
                    return;
                end
                done_i = noise ? (4'($urandom) & ~sel) : 4'b0000;
                if (j == k) done_i = done_i | sel;
                run_i = noise ? 1'($urandom) : 1'b0;
            end
            tick();
            done_i = 4'b0000;
            run_i  = 1'b0;
        end
        if (m == 3'b001) kv_m = 1'b1;
        exp = {1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, kv_m};
        n_checks++;
        if (obs !== exp || err_code_o !== ERR_NONE) begin
            n_fail++;
            $display("FAIL done m=%b: got %b/%0d want %b/0", m, obs, err_code_o, exp);
        end
        tick();
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, kv_m};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL done_idle m=%b: got %b want %b", m, obs, exp);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (obs !== 9'b1_0_0_0_0000_0 || err_code_o !== ERR_NONE || step_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset: got %b/%0d step %0d want 100000000/0 step 0", obs, err_code_o, step_o);
        end
    endtask

    task automatic test_nokey();
        drive_request(3'b100, 1, -1, 0, -1, 1'b0);
    endtask

    task automatic test_badmode();
        drive_request(3'b110, 1, -1, 0, -1, 1'b0);
        drive_request(3'b000, 1, -1, 0, -1, 1'b0);
    endtask

    task automatic test_keygen();
        drive_request(3'b001, 1, -1, 0, -1, 1'b0);
    endtask

    task automatic test_timeout();
        drive_request(3'b010, 1, 2, 0, -1, 1'b0);
        drive_request(3'b010, 1, 2, int'(TO), -1, 1'b0);
    endtask

    task automatic test_abort();
        drive_request(3'b001, 1, -1, 0, -1, 1'b0);
        drive_request(3'b100, 1, -1, 0, 1, 1'b0);
        drive_request(3'b100, 1, -1, 0, -1, 1'b0);
    endtask

    // Abort in IDLE must also beat a simultaneous request.
    task automatic test_abort_idle();
        drive_request(3'b001, 1, -1, 0, -1, 1'b0);
        run_i   = 1'b1;
        mode_i  = MODE_KEYGEN;
        abort_i = 1'b1;
        tick();
        run_i   = 1'b0;
        abort_i = 1'b0;
        kv_m    = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (obs !== 9'b1_0_0_0_0000_0) begin
                n_fail++;
                $display("FAIL abort_idle c=%0d: got %b want 100000000", c, obs);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] m;
        int r;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      m = 3'($urandom);
            else if (r < 4)  m = 3'b001;
            else if (r < 7)  m = 3'b010;
            else             m = 3'b100;
            drive_request(m, 0, -1, 0, -1, 1'b1);
        end
    endtask

    task automatic test_async_reset();
        run_i  = 1'b1;
        mode_i = MODE_KEYGEN;
        tick();
        run_i  = 1'b0;
        n_checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, kv_m}) begin
            n_fail++;
            $display("FAIL areset_issue: got %b want 0100 0001 %b", obs, kv_m);
        end
        tick();
        #2 rst_n_i = 1'b0;
        #1;
        kv_m = 1'b0;
        n_checks++;
        if (obs !== 9'b1_0_0_0_0000_0 || step_o !== 3'd0 || err_code_o !== ERR_NONE) begin
            n_fail++;
            $display("FAIL areset: got %b step %0d err %0d want 100000000 step 0 err 0",
                     obs, step_o, err_code_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        drive_request(3'b001, 1, -1, 0, -1, 1'b0);
    endtask

    initial begin
        rst_n_i = 1'b0;
        run_i   = 1'b0;
        abort_i = 1'b0;
        done_i  = 4'b0000;
        mode_i  = MODE_KEYGEN;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        test_reset();
        test_nokey();
        test_badmode();
        test_keygen();
        test_timeout();
        test_abort();
        test_abort_idle();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
